sensor_packetizer: RTL and testbench

- Sits directly downstream of the 8-bit sensor front-end.
- Strobes the sensor at a programmable sample rate and buffers samples in a small FIFO.
- Frames every PAYLOAD_LEN samples into a byte-serial packet (node ID, sequence, payload, checksum) for the radio TX stage.
- The TX side uses a valid/ready handshake.

---
 rtl/sensor_pkt_pkg.sv | 27 ++
 rtl/sample_fifo.sv | 66 ++++++
 rtl/sensor_packetizer.sv | 168 ++++++++++++++++
 tb/tb_sensor_packetizer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkt_pkg.sv
// Shared types and helpers for the sensor packetizer: FSM state encoding, byte width
// and the CRC-8 byte-update function used when the CRC checksum build is selected.
package sensor_pkt_pkg;

  localparam int unsigned ByteW = 8;
  localparam logic [ByteW-1:0] Crc8Poly = 8'h07;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StSeq,
    StPayload,
    StCsum
  } pkt_state_e;

  // MSB-first CRC-8 over one byte, no reflection, no final XOR.
  function automatic logic [ByteW-1:0] crc8_update(input logic [ByteW-1:0] crc,
                                                   input logic [ByteW-1:0] data);
    logic [ByteW-1:0] c;
    c = crc ^ data;
    for (int i = 0; i < ByteW; i++) begin
      c = c[ByteW-1] ? ((c << 1) ^ Crc8Poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO for buffered sensor samples. A push into a full FIFO is accepted only
// when a pop happens in the same cycle; otherwise it is ignored and the contents stay intact.
module sample_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8,
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AddrW:0]   count_o
);

  localparam logic [AddrW-1:0] PtrLast = AddrW'(Depth - 1);
  localparam logic [AddrW:0]   CountFull = (AddrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CountFull);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + AddrW'(1);
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + AddrW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AddrW + 1)'(1);
      2'b01:   count_d = count_q - (AddrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: empty entries are never presented downstream.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sensor_packetizer.sv
// Samples the sensor every SAMPLE_DIV cycles into a FIFO and frames PAYLOAD_LEN samples per
// packet as HDR, SEQ, payload, checksum. Define SENSOR_PKT_CRC8_EN for a CRC-8 checksum byte.
module sensor_packetizer
  import sensor_pkt_pkg::*;
#(
  parameter logic [ByteW-1:0] NODE_ID     = 8'h01,
  parameter int unsigned      SAMPLE_DIV  = 10,
  parameter int unsigned      PAYLOAD_LEN = 4,
  parameter int unsigned      FIFO_DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  output logic                        sense_en,
  input  logic [ByteW-1:0]            sensor_data,
  output logic [ByteW-1:0]            tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        tx_last,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned CntW   = $clog2(SAMPLE_DIV);
  localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PayW   = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;

  localparam logic [CntW-1:0]   CntLast   = CntW'(SAMPLE_DIV - 1);
  localparam logic [PayW-1:0]   PayLast   = PayW'(PAYLOAD_LEN - 1);
  localparam logic [CountW-1:0] PktThresh = CountW'(PAYLOAD_LEN);

  function automatic logic [ByteW-1:0] csum_step(input logic [ByteW-1:0] acc,
                                                 input logic [ByteW-1:0] b);
`ifdef SENSOR_PKT_CRC8_EN
    return crc8_update(acc, b);
`else
    return acc ^ b;
`endif
  endfunction

  pkt_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PayW-1:0]  pay_cnt_q, pay_cnt_d;
  logic [ByteW-1:0] seq_q, seq_d;
  logic [ByteW-1:0] csum_q, csum_d;
  logic             sense_en_q;
  logic             overflow_q, overflow_d;

  logic             strike;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ByteW-1:0] fifo_rdata;
  logic             pkt_ready;
  logic             tx_fire;

  // Sampler: free-running divider while enabled, parked at zero otherwise.
  assign strike = enable && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || (cnt_q == CntLast)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign overflow_d = overflow_q | (strike & fifo_full & ~fifo_pop);

  sample_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (ByteW)
  ) u_sample_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (strike),
    .wdata_i (sensor_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign pkt_ready = (fifo_count >= PktThresh);
  assign sense_en  = sense_en_q;
  assign overflow  = overflow_q;

  always_comb begin
    state_d   = state_q;
    pay_cnt_d = pay_cnt_q;
    seq_d     = seq_q;
    csum_d    = csum_q;
    tx_valid  = 1'b0;
    tx_data   = '0;
    tx_last   = 1'b0;
    fifo_pop  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pkt_ready) state_d = StHdr;
      end
      StHdr: begin
        tx_valid = 1'b1;
        tx_data  = NODE_ID;
        if (tx_ready) state_d = StSeq;
      end
      StSeq: begin
        tx_valid = 1'b1;
        tx_data  = seq_q;
        if (tx_ready) begin
          state_d   = StPayload;
          pay_cnt_d = '0;
        end
      end
      StPayload: begin
        tx_valid = 1'b1;
        tx_data  = fifo_rdata;
        if (tx_ready) begin
          fifo_pop = !fifo_empty;
          if (pay_cnt_q == PayLast) begin
            state_d = StCsum;
          end else begin
            pay_cnt_d = pay_cnt_q + PayW'(1);
          end
        end
      end
      StCsum: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        tx_last  = 1'b1;
        if (tx_ready) begin
          seq_d   = seq_q + 8'd1;
          state_d = pkt_ready ? StHdr : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    tx_fire = tx_valid && tx_ready;
    // Checksum covers every byte before the checksum itself, restarting for each packet.
    if (tx_fire) begin
      csum_d = (state_q == StCsum) ? '0 : csum_step(csum_q, tx_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pay_cnt_q  <= '0;
      seq_q      <= '0;
      csum_q     <= '0;
      sense_en_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pay_cnt_q  <= pay_cnt_d;
      seq_q      <= seq_d;
      csum_q     <= csum_d;
      sense_en_q <= enable;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_sensor_packetizer.sv
// Scoreboard bench for sensor_packetizer: a queue-based sample/packet model predicts the byte
// stream; a monitor pops and compares each accepted byte.
module tb_sensor_packetizer;

  localparam logic [7:0] NodeId    = 8'h01;
  localparam int         SampleDiv = 10;
  localparam int         PayLen    = 4;
  localparam int         FifoDepth = 8;
  localparam int         PktBytes  = PayLen + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       sense_en;
  logic [7:0] sensor_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;
  logic       overflow;
  logic [3:0] fifo_count;

  sensor_packetizer #(
    .NODE_ID     (NodeId),
    .SAMPLE_DIV  (SampleDiv),
    .PAYLOAD_LEN (PayLen),
    .FIFO_DEPTH  (FifoDepth)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .sense_en    (sense_en),
    .sensor_data (sensor_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_last     (tx_last),
    .overflow    (overflow),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL timeout_%s actual=expired required=event at %0t", name, $time);
  endtask

  // Reference checksum, written bit-serially.
  function automatic logic [7:0] ref_sum(input logic [7:0] b[$]);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    foreach (b[i]) begin
`ifdef SENSOR_PKT_CRC8_EN
      for (int k = 7; k >= 0; k--) begin
        fb = c[7] ^ b[i][k];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
`else
      fb = 1'b0;
      c  = c ^ b[i];
`endif
    end
    return c;
  endfunction

  // Stimulus controls driven into the DUT by the driver process below.
  bit         use_pat   = 1'b1;
  bit         rand_rdy  = 1'b0;
  bit         ready_set = 1'b1;
  logic [7:0] pat [4];

  // Model state.
  int         run;
  int         n_strk;
  int         occ;
  bit         ovf_m;
  bit         prev_en;
  int         hs_pos;
  logic [7:0] seq_m;
  logic [7:0] pend[$];
  logic [8:0] exp_q[$];

  // Monitor state.
  int         mon_pos;
  int         pres_pos;
  int         n_pkts;
  logic [7:0] seq_hist [300];

  always @(posedge clk) begin
    #2;
    sensor_data = use_pat ? pat[n_strk % 4] : 8'($urandom);
    tx_ready    = rand_rdy ? (($urandom % 4) != 0) : ready_set;
  end

  task automatic build_packet();
    logic [7:0] bytes[$];
    bytes.push_back(NodeId);
    bytes.push_back(seq_m);
    foreach (pend[i]) bytes.push_back(pend[i]);
    foreach (bytes[i]) exp_q.push_back({1'b0, bytes[i]});
    exp_q.push_back({1'b1, ref_sum(bytes)});
    seq_m = seq_m + 8'd1;
    pend.delete();
  endtask

  // Model: predicts what the next rising edge does, from the inputs stable at this negedge.
  always @(negedge clk) begin
    bit pop_now;
    bit strk;
    if (!rst_n) begin
      run = 0; n_strk = 0; occ = 0; ovf_m = 0; prev_en = 0; hs_pos = 0; seq_m = 8'h00;
      pend.delete();
      exp_q.delete();
    end else begin
      check("fifo_count", fifo_count, occ);
      check("overflow", overflow, ovf_m);
      check("sense_en", sense_en, prev_en);
      pop_now = 1'b0;
      if (tx_valid && tx_ready) begin
        pop_now = (hs_pos >= 2) && (hs_pos < 2 + PayLen);
        hs_pos  = (hs_pos + 1) % PktBytes;
      end
      strk = 1'b0;
      if (enable) begin
        run++;
        strk = (run % SampleDiv) == 0;
      end else begin
        run = 0;
      end
      if (strk) begin
        n_strk++;
        if (occ < FifoDepth || pop_now) begin
          occ++;
          pend.push_back(sensor_data);
          if (pend.size() == PayLen) build_packet();
        end else begin
          ovf_m = 1'b1;
        end
      end
      if (pop_now) occ--;
      prev_en = enable;
    end
  end

  // Monitor: every accepted byte is compared against the head of the expected queue.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      mon_pos = 0; pres_pos = 0; n_pkts = 0;
    end else begin
      pres_pos = mon_pos;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%0h required=none at %0t", tx_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", tx_data, e[7:0]);
          check("tx_last", tx_last, e[8]);
        end
        if (mon_pos == 1 && n_pkts < 300) seq_hist[n_pkts] = tx_data;
        if (mon_pos == PktBytes - 1) n_pkts++;
        mon_pos = (mon_pos + 1) % PktBytes;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_pres(input int pos, input int limit, input string name);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(tx_valid && pres_pos == pos) && n < limit);
    if (n >= limit) timeout_fail(name);
  endtask

  task automatic wait_pkts(input int target, input int limit, input string name);
    int n = 0;
    while (n_pkts < target && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= limit) timeout_fail(name);
  endtask

  initial begin
    logic [7:0] basic[$];
    logic [7:0] basic_sum;
    pat[0] = 8'h00; pat[1] = 8'h40; pat[2] = 8'h80; pat[3] = 8'hBF;
    basic = {8'h01, 8'h00, 8'h00, 8'h40, 8'h80, 8'hBF};
    basic_sum = ref_sum(basic);

    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_last", tx_last, 0);
    check("rst_overflow", overflow, 0);
    check("rst_sense_en", sense_en, 0);
    check("rst_fifo_count", fifo_count, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic packet with backpressure on the second payload byte.
    @(posedge clk); #1 enable = 1'b1;
    wait_pres(2, 300, "first_payload");
    @(posedge clk); #1 ready_set = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_tx_valid", tx_valid, 1);
      check("bp_tx_data", tx_data, 8'h40);
    end
    @(posedge clk); #1 ready_set = 1'b1;
    wait_pres(6, 50, "first_csum");
    check("basic_csum", tx_data, basic_sum);
    check("basic_last", tx_last, 1);
    wait_pkts(2, 200, "second_packet");
    check("basic_seq1", seq_hist[1], 8'h01);

    // Enable dropped mid-packet: the packet finishes, then nothing more is sampled.
    use_pat = 1'b0;
    wait_pres(3, 200, "en_drop_mid");
    @(posedge clk); #1 enable = 1'b0;
    wait_pkts(n_pkts + 1, 50, "en_drop_finish");
    repeat (4 * SampleDiv) @(posedge clk);
    @(negedge clk);
    check("en_drop_idle", tx_valid, 0);
    check("en_drop_drained", exp_q.size(), 0);

    // Reset mid-payload.
    @(posedge clk); #1 enable = 1'b1;
    wait_pres(3, 200, "rst_mid");
    @(posedge clk); #1 rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_fifo_count", fifo_count, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 enable = 1'b1;
    wait_pres(1, 200, "post_rst_seq");
    check("post_rst_seq", tx_data, 8'h00);

    // Overflow: stall the radio for nine strikes.
    do_reset();
    ready_set = 1'b0;
    enable = 1'b1;
    repeat (91) @(posedge clk);
    @(negedge clk);
    check("ovf_flag", overflow, 1);
    check("ovf_count", fifo_count, 8);
    @(posedge clk); #1 ready_set = 1'b1;
    enable = 1'b0;
    wait_pkts(2, 100, "ovf_drain");
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("ovf_sticky", overflow, 1);
    check("ovf_drained", exp_q.size(), 0);

    // Sequence wrap with random data and random backpressure.
    do_reset();
    rand_rdy = 1'b1;
    enable = 1'b1;
    wait_pkts(257, 257 * PktBytes * 8 + 257 * SampleDiv * PayLen, "wrap");
    check("wrap_seq_ff", seq_hist[255], 8'hFF);
    check("wrap_seq_00", seq_hist[256], 8'h00);
    @(posedge clk); #1 enable = 1'b0;
    rand_rdy = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
